// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction-fetch stage with imem req/ack handshake
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC
    } state_t;

    state_t      state;
    logic [31:0] sel_pc;
    logic [31:0] next_pc;

    // Jump outranks branch; the chosen target is word-aligned before it reaches the PC.
    always_comb begin
        sel_pc = i_pc_plus4;
        if (i_jump) begin
            sel_pc = i_jump_target;
        end else if (i_branch_taken) begin
            sel_pc = i_branch_target;
        end
        next_pc = sel_pc & 32'hFFFF_FFFC;
    end

    assign o_imem_addr = o_pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            o_pc          <= RESET_PC;
            o_imem_req    <= 1'b0;
            o_instr_valid <= 1'b0;
            o_instr       <= 32'h0000_0000;
            o_retired     <= 32'h0000_0000;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_REQ;
                    o_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (i_imem_ack) begin
                        o_instr       <= i_imem_data;
                        o_instr_valid <= 1'b1;
                        o_imem_req    <= 1'b0;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!i_stall) begin
                        o_pc          <= next_pc;
                        o_retired     <= o_retired + 32'd1;
                        o_instr_valid <= 1'b0;
                        o_imem_req    <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    o_imem_req    <= 1'b0;
                    o_instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, pc_plus4, addr, instr, retired;
    logic        branch_taken, jump, stall, req, ack, valid;
    logic [31:0] branch_target, jump_target, imem_data;

    logic [31:0] w_pc, w_pc_plus4, w_addr, w_instr, w_retired, w_data;
    logic        w_req, w_ack, w_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign pc_plus4   = pc + 32'd4;
    assign w_pc_plus4 = w_pc + 32'd4;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_pc(pc), .i_pc_plus4(pc_plus4),
        .i_branch_taken(branch_taken), .i_branch_target(branch_target),
        .i_jump(jump), .i_jump_target(jump_target), .i_stall(stall),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack),
        .i_imem_data(imem_data), .o_instr(instr), .o_instr_valid(valid),
        .o_retired(retired)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .o_pc(w_pc), .i_pc_plus4(w_pc_plus4),
        .i_branch_taken(1'b0), .i_branch_target(32'h0),
        .i_jump(1'b0), .i_jump_target(32'h0), .i_stall(1'b0),
        .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(w_ack),
        .i_imem_data(w_data), .o_instr(w_instr), .o_instr_valid(w_valid),
        .o_retired(w_retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        ack = 1'b0; imem_data = 32'h0; w_ack = 1'b0; w_data = 32'h0;
        #1;
        repeat (3) tick();

        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        tick();
        chk("rel_req", {31'b0, req}, 32'h1);

        // Sequential fetch, zero-wait memory
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", addr, 32'(4 * i));
            chk("seq_req", {31'b0, req}, 32'h1);
            chk("seq_valid_lo", {31'b0, valid}, 32'h0);
            ack = 1'b1; imem_data = 32'hA000_0000 + 32'(i);
            tick();
            ack = 1'b0;
            chk("seq_valid_hi", {31'b0, valid}, 32'h1);
            chk("seq_instr", instr, 32'hA000_0000 + 32'(i));
            chk("seq_req_lo", {31'b0, req}, 32'h0);
            chk("seq_pc_hold", pc, 32'(4 * i));
            tick();
            chk("seq_pc_next", pc, 32'(4 * (i + 1)));
            chk("seq_retired", retired, 32'(i + 1));
        end

        // Memory wait states: req already high one cycle, three more without ack
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'b0, req}, 32'h1);
            chk("wait_valid", {31'b0, valid}, 32'h0);
        end
        ack = 1'b1; imem_data = 32'h1234_0010;
        tick();
        ack = 1'b0;
        chk("wait_valid_hi", {31'b0, valid}, 32'h1);
        chk("wait_instr", instr, 32'h1234_0010);

        // Two stall cycles; the first also carries a stray ack
        stall = 1'b1; ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        chk("stray_instr", instr, 32'h1234_0010);
        chk("stall_pc1", pc, 32'h10);
        chk("stall_ret1", retired, 32'd4);
        chk("stall_valid1", {31'b0, valid}, 32'h1);
        tick();
        chk("stall_pc2", pc, 32'h10);
        chk("stall_ret2", retired, 32'd4);
        chk("stall_valid2", {31'b0, valid}, 32'h1);
        chk("stall_req", {31'b0, req}, 32'h0);

        // Jump beats branch, target aligned
        stall = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h203;
        tick();
        chk("jump_pc", pc, 32'h200);
        chk("jump_ret", retired, 32'd5);
        chk("jump_req", {31'b0, req}, 32'h1);

        // Branch only; redirect inputs stay asserted through S_REQ and must be ignored there
        jump = 1'b0;
        ack = 1'b1; imem_data = 32'h0000_0BBB;
        tick();
        ack = 1'b0;
        chk("br_req_pc", pc, 32'h200);
        tick();
        chk("branch_pc", pc, 32'h100);
        chk("branch_ret", retired, 32'd6);
        branch_taken = 1'b0;

        // Reset during S_REQ with a coincident ack
        rst_n = 1'b0; ack = 1'b1; imem_data = 32'h1234_5678;
        tick();
        ack = 1'b0;
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_valid", {31'b0, valid}, 32'h0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_req", {31'b0, req}, 32'h0);
        chk("mrst_retired", retired, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mrst_rel_req", {31'b0, req}, 32'h1);

        // Wrap-around from 0xFFFF_FFFC
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        chk("wrap_req0", {31'b0, w_req}, 32'h1);
        w_ack = 1'b1; w_data = 32'h0000_0013;
        tick();
        w_ack = 1'b0;
        chk("wrap_valid", {31'b0, w_valid}, 32'h1);
        tick();
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_req1", {31'b0, w_req}, 32'h1);
        chk("wrap_retired", w_retired, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
